hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised pipeline hazard unit; successor to the fixed 3-deep, stall-only hazard controller.
//  Tracks DEPTH in-flight register writers in a scoreboard shift chain.
//  Selects a forwarding source per operand, or asserts a load-use/data hazard when forwarding is off.
//  Also generates multi-cycle control-hazard flushes, memory stalls and saturating hazard event counters.
//  Sits beside the decode stage; drives the pipeline-latch stall/flush controls and the operand bypass muxes.
// PARAMETERS
//  ADDR_W    5   register address width
//  DEPTH     3   writer stages tracked after decode, >=1 (entry 0 = EX, entry DEPTH-1 = oldest)
//  FWD_EN    1   1: forward from matching entries; 0: any match raises data_hazard
//  FLUSH_CYC 2   cycles control_hazard is held per taken jump, >=1
//  CNT_W     16  width of each event counter
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous reset, active-low
//  jump_taken     in   1        branch/jump resolved taken this cycle
//  imem_ready     in   1        instruction memory ready
//  dmem_ready     in   1        data memory ready
//  dmem_use       in   1        instruction in MEM is accessing data memory
//  issue_valid    in   1        decode holds a valid instruction
//  a0             in   ADDR_W   decode source register 1
//  a1             in   ADDR_W   decode source register 2
//  a2             in   ADDR_W   decode destination register
//  rd_wen         in   1        decode instruction writes a2
//  rd_is_load     in   1        decode instruction is a load
//  control_hazard out  1        flush younger stages
//  data_hazard    out  1        hold fetch/decode, insert bubble
//  stall          out  1        freeze the whole pipeline
//  dmem_stall     out  1        data memory wait
//  imem_stall     out  1        instruction memory wait
//  fwd_sel0       out  SEL_W    bypass select for a0; 0 = regfile, k+1 = entry k; SEL_W=$clog2(DEPTH+1)
//  fwd_sel1       out  SEL_W    bypass select for a1; same encoding
//  hz_cnt         out  CNT_W    data-hazard cycle count, saturating
//  ch_cnt         out  CNT_W    control-hazard cycle count, saturating
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - All entries invalid; flush counter 0; hz_cnt and ch_cnt 0.
//   - Outputs then follow purely from inputs: control_hazard=jump_taken; data_hazard=0; fwd_sel*=0.
//  Entry format: {valid, addr[ADDR_W], is_load}.
//  Entry match (operand x): valid & addr==x & x!=0.
//  Priority: youngest match (lowest k) wins.
//  Forwarding, FWD_EN=1:
//   - Youngest match at entry 0 with is_load => load-use; data_hazard requested, fwd_sel=0.
//   - Any other youngest match at entry k => fwd_sel=k+1.
//  Forwarding, FWD_EN=0: any match => data_hazard requested; fwd_sel*=0.
//  data_hazard = issue_valid & (request on a0 | request on a1) & ~control_hazard.
//  Memory stalls and stall:
//   - dmem_stall = ~dmem_ready & dmem_use.
//   - imem_stall = ~imem_ready.
//   - stall = dmem_stall | (imem_stall & ~dmem_use & jump_taken).
//  Chain update on each clk edge:
//   - stall=1: hold all entries, the flush counter and both event counters.
//   - Otherwise entry k <= entry k-1 for k>=1.
//   - Entry 0 <= {1,a2,rd_is_load} iff issue_valid & rd_wen & a2!=0 & ~data_hazard & ~control_hazard.
//   - Else entry 0 <= bubble (invalid).
//  Flush counter (not stalled):
//   - jump_taken loads FLUSH_CYC-1; a new jump during a flush reloads it.
//   - Else decrements to 0.
//   - control_hazard = jump_taken | (cnt!=0); FLUSH_CYC=1 gives a pure combinational pass-through.
//  Event counters (not stalled):
//   - hz_cnt += data_hazard; ch_cnt += control_hazard.
//   - Each saturates at all-ones, no wrap.
//  Simultaneous events:
//   - control_hazard masks data_hazard; stall dominates all state updates.
//   - Reset mid-flush or mid-hazard clears state immediately.
// TESTING
//  T1 Forward from EX: write x5 then read a0=5 next cycle -> data_hazard=0, fwd_sel0=1.
//  T2 Load-use: load x7, next a1=7 -> data_hazard=1 for 1 cycle, then fwd_sel1=2, bubble in entry 0.
//  T3 FWD_EN=0, DEPTH=3: write x3, read x3 -> data_hazard=1 for exactly 3 cycles; x0 never hazards.
//  T4 Jump with FLUSH_CYC=2 -> control_hazard high 2 cycles, data_hazard masked.
//  T4a Second jump in cycle 2 -> control_hazard held to 3 cycles.
//  T5 dmem_use=1, dmem_ready=0 for 4 cycles -> stall=1 for 4 cycles, chain/counters frozen.
//  T5a Assert rst=0 mid-stall -> entries and counters 0 asynchronously.
//  T6 CNT_W=4, force 20 data-hazard cycles -> hz_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: writer scoreboard, operand bypass selects,
// load-use/data hazards, control flush window, memory stalls, event counters.
module hazard_forward_unit #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_taken,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              dmem_use,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic              rd_wen,
  input  logic              rd_is_load,
  output logic              control_hazard,
  output logic              data_hazard,
  output logic              stall,
  output logic              dmem_stall,
  output logic              imem_stall,
  output logic [SEL_W-1:0]  fwd_sel0,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [CNT_W-1:0]  hz_cnt,
  output logic [CNT_W-1:0]  ch_cnt
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYC - 1);

  logic [DEPTH-1:0]  ev;
  logic [DEPTH-1:0]  el;
  logic [ADDR_W-1:0] ea [DEPTH];
  logic [FW-1:0]     fcnt;

  logic [ADDR_W-1:0] src [2];
  logic [1:0]        req;
  logic [SEL_W-1:0]  sel [2];
  logic              wr;

  assign src[0] = a0;
  assign src[1] = a1;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      req[o] = 1'b0;
      sel[o] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ev[k] && ea[k] == src[o] && src[o] != '0) begin
          if (FWD_EN == 0 || (k == 0 && el[k])) begin
            req[o] = 1'b1;
            sel[o] = '0;
          end else begin
            req[o] = 1'b0;
            sel[o] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  assign fwd_sel0       = sel[0];
  assign fwd_sel1       = sel[1];
  assign control_hazard = jump_taken | (fcnt != '0);
  assign data_hazard    = issue_valid & (|req) & ~control_hazard;
  assign dmem_stall     = ~dmem_ready & dmem_use;
  assign imem_stall     = ~imem_ready;
  assign stall          = dmem_stall
                        | (imem_stall & ~dmem_use & jump_taken);

  assign wr = issue_valid & rd_wen & (a2 != '0)
            & ~data_hazard & ~control_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev <= '0;
      el <= '0;
      for (int k = 0; k < DEPTH; k++) ea[k] <= '0;
    end else if (!stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ev[k] <= ev[k-1];
        el[k] <= el[k-1];
        ea[k] <= ea[k-1];
      end
      ev[0] <= wr;
      el[0] <= wr & rd_is_load;
      ea[0] <= wr ? a2 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
    end else if (!stall) begin
      if (jump_taken)       fcnt <= FLOAD;
      else if (fcnt != '0)  fcnt <= fcnt - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hz_cnt <= '0;
      ch_cnt <= '0;
    end else if (!stall) begin
      if (data_hazard && hz_cnt != '1)
        hz_cnt <= hz_cnt + CNT_W'(1);
      if (control_hazard && ch_cnt != '1)
        ch_cnt <= ch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboarded directed bench: forwarding instance plus a
// stall-only (FWD_EN=0, CNT_W=4) instance sharing most inputs.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic jt = 0, imr = 1, dmr = 1, du = 0;
  logic iva = 0, ivb = 0, wen = 0, ld = 0;
  logic [4:0] a0 = 0, a1 = 0, a2 = 0;

  logic        ch, dh, st, dms, ims;
  logic [1:0]  s0, s1;
  logic [15:0] hz, cc;

  logic        chb, dhb, stb, dmsb, imsb;
  logic [1:0]  s0b, s1b;
  logic [3:0]  hzb, ccb;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .jump_taken(jt),
    .imem_ready(imr), .dmem_ready(dmr),
    .dmem_use(du), .issue_valid(iva),
    .a0(a0), .a1(a1), .a2(a2),
    .rd_wen(wen), .rd_is_load(ld),
    .control_hazard(ch), .data_hazard(dh),
    .stall(st), .dmem_stall(dms),
    .imem_stall(ims), .fwd_sel0(s0),
    .fwd_sel1(s1), .hz_cnt(hz), .ch_cnt(cc)
  );

  hazard_forward_unit #(.FWD_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .jump_taken(jt),
    .imem_ready(imr), .dmem_ready(dmr),
    .dmem_use(du), .issue_valid(ivb),
    .a0(a0), .a1(a1), .a2(a2),
    .rd_wen(wen), .rd_is_load(ld),
    .control_hazard(chb), .data_hazard(dhb),
    .stall(stb), .dmem_stall(dmsb),
    .imem_stall(imsb), .fwd_sel0(s0b),
    .fwd_sel1(s1b), .hz_cnt(hzb), .ch_cnt(ccb)
  );

  typedef struct {
    bit          b;
    int          id;
    logic        ch, dh, st, dms, ims;
    logic [1:0]  s0, s1;
    logic [15:0] hz, cc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int sid = 0;

  task automatic chk(string nm, int id,
                     logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d want %0d",
               nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.b) begin
        chk("control_hazard", e.id, 16'(ch), 16'(e.ch));
        chk("data_hazard", e.id, 16'(dh), 16'(e.dh));
        chk("stall", e.id, 16'(st), 16'(e.st));
        chk("dmem_stall", e.id, 16'(dms), 16'(e.dms));
        chk("imem_stall", e.id, 16'(ims), 16'(e.ims));
        chk("fwd_sel0", e.id, 16'(s0), 16'(e.s0));
        chk("fwd_sel1", e.id, 16'(s1), 16'(e.s1));
        chk("hz_cnt", e.id, hz, e.hz);
        chk("ch_cnt", e.id, cc, e.cc);
      end else begin
        chk("b_data_hazard", e.id, 16'(dhb), 16'(e.dh));
        chk("b_hz_cnt", e.id, 16'(hzb), e.hz);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ea(logic c, logic d, logic s,
                    logic dm, logic im,
                    logic [1:0] f0, logic [1:0] f1,
                    int h, int k);
    exp_t e;
    e.b = 0; e.id = sid++;
    e.ch = c; e.dh = d; e.st = s;
    e.dms = dm; e.ims = im;
    e.s0 = f0; e.s1 = f1;
    e.hz = 16'(h); e.cc = 16'(k);
    q.push_back(e);
  endtask

  task automatic eb(logic d, int h);
    exp_t e;
    e = '{default: 0};
    e.b = 1; e.id = sid++;
    e.dh = d; e.hz = 16'(h);
    q.push_back(e);
  endtask

  initial begin
    int hzm;
    int budget;
    // reset: outputs purely combinational from inputs
    cyc(); jt = 1;
    ea(1,0,0,0,0,0,0,0,0);
    cyc(); rst = 1; jt = 0; iva = 1;
    a2 = 5; wen = 1;
    ea(0,0,0,0,0,0,0,0,0);
    cyc(); a0 = 5; wen = 0;
    ea(0,0,0,0,0,1,0,0,0);
    cyc(); a1 = 5;
    ea(0,0,0,0,0,2,2,0,0);
    cyc(); a0 = 0; a1 = 0; a2 = 7; wen = 1; ld = 1;
    ea(0,0,0,0,0,0,0,0,0);
    cyc(); a1 = 7; wen = 0; ld = 0;
    ea(0,1,0,0,0,0,0,0,0);
    cyc(); a0 = 7; a2 = 0; wen = 1;
    ea(0,0,0,0,0,2,2,1,0);
    cyc(); a0 = 0; a1 = 0; wen = 0;
    ea(0,0,0,0,0,0,0,1,0);
    cyc(); a2 = 9; wen = 1;
    ea(0,0,0,0,0,0,0,1,0);
    cyc(); a0 = 9;
    ea(0,0,0,0,0,1,0,1,0);
    cyc(); wen = 0;
    ea(0,0,0,0,0,1,0,1,0);
    cyc();
    ea(0,0,0,0,0,2,0,1,0);
    cyc(); a0 = 0; a2 = 4; wen = 1; ld = 1;
    ea(0,0,0,0,0,0,0,1,0);
    cyc(); iva = 0; a0 = 4; wen = 0; ld = 0;
    ea(0,0,0,0,0,0,0,1,0);
    cyc(); iva = 1; a0 = 0; a2 = 8; wen = 1; ld = 1;
    ea(0,0,0,0,0,0,0,1,0);
    // jump masks a pending load-use
    cyc(); jt = 1; a1 = 8; wen = 0; ld = 0;
    ea(1,0,0,0,0,0,0,1,0);
    cyc(); jt = 0;
    ea(1,0,0,0,0,0,2,1,1);
    cyc(); a1 = 0;
    ea(0,0,0,0,0,0,0,1,2);
    cyc(); jt = 1;
    ea(1,0,0,0,0,0,0,1,2);
    cyc();
    ea(1,0,0,0,0,0,0,1,3);
    cyc(); jt = 0;
    ea(1,0,0,0,0,0,0,1,4);
    cyc();
    ea(0,0,0,0,0,0,0,1,5);
    cyc(); a2 = 10; wen = 1;
    ea(0,0,0,0,0,0,0,1,5);
    // data memory stall freezes chain, flush counter and counters
    for (int i = 0; i < 4; i++) begin
      cyc(); du = 1; dmr = 0; wen = 0; a0 = 10; jt = 1;
      ea(1,0,1,1,0,1,0,1,5);
    end
    cyc(); du = 0; dmr = 1; jt = 0;
    ea(0,0,0,0,0,1,0,1,5);
    cyc(); imr = 0;
    ea(0,0,0,0,1,2,0,1,5);
    cyc(); jt = 1;
    ea(1,0,1,0,1,3,0,1,5);
    cyc(); du = 1;
    ea(1,0,0,0,1,3,0,1,5);
    cyc(); imr = 1; du = 0; jt = 0; a0 = 0;
    ea(1,0,0,0,0,0,0,1,6);
    cyc(); a2 = 11; wen = 1;
    ea(0,0,0,0,0,0,0,1,7);
    cyc(); du = 1; dmr = 0; a0 = 11; wen = 0;
    ea(0,0,1,1,0,1,0,1,7);
    // asynchronous reset in the middle of a stall
    cyc(); rst = 0;
    ea(0,0,1,1,0,0,0,0,0);
    cyc(); rst = 1; du = 0; dmr = 1; a0 = 0;
    ea(0,0,0,0,0,0,0,0,0);
    // stall-only instance
    cyc(); iva = 0; ivb = 1; a2 = 3; wen = 1;
    eb(0, 0);
    cyc(); a0 = 3; wen = 0;
    eb(1, 0);
    cyc(); eb(1, 1);
    cyc(); eb(1, 2);
    cyc(); eb(0, 3);
    cyc(); a0 = 0; a2 = 0; wen = 1;
    eb(0, 3);
    cyc(); wen = 0;
    eb(0, 3);
    hzm = 3;
    for (int r = 0; r < 7; r++) begin
      cyc(); a2 = 2; wen = 1; a0 = 0;
      eb(0, hzm);
      for (int j = 0; j < 3; j++) begin
        cyc(); wen = 0; a0 = 2;
        eb(1, hzm);
        hzm = (hzm < 15) ? hzm + 1 : 15;
      end
    end
    cyc(); a0 = 0;
    eb(0, 15);
    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
